// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall/flush, valid and Tnew countdown.
// Optional FLUSH_KEEP_PC_EN: a bubble keeps PC_in (squashed slot PC) instead of RESET_PC.
module pipe_stage_reg #(
  parameter int              DW       = 32,
  parameter int              AW       = 5,
  parameter int              PCW      = 32,
  parameter int              IW       = 32,
  parameter int              TW       = 2,
  parameter logic [PCW-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            valid_in,
  input  logic [DW-1:0]   WD_in,
  input  logic [AW-1:0]   WR_in,
  input  logic            RegWrite_in,
  input  logic [PCW-1:0]  PC_in,
  input  logic [IW-1:0]   Instr_in,
  input  logic [TW-1:0]   Tnew_in,
  output logic            valid_out,
  output logic [DW-1:0]   WD_out,
  output logic [AW-1:0]   WR_out,
  output logic            RegWrite_out,
  output logic [PCW-1:0]  PC_out,
  output logic [IW-1:0]   Instr_out,
  output logic [TW-1:0]   Tnew_out,
  output logic            fwd_ready
);

  logic          reg_write_qual;
  logic [TW-1:0] tnew_next;
  logic [PCW-1:0] bubble_pc;

  // Writes to $0 and from empty slots never reach the hazard/forwarding logic.
  assign reg_write_qual = RegWrite_in & valid_in & (WR_in != '0);
  assign tnew_next      = (Tnew_in == '0) ? '0 : Tnew_in - TW'(1);

`ifdef FLUSH_KEEP_PC_EN
  assign bubble_pc = PC_in;
`else
  assign bubble_pc = RESET_PC;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out    <= 1'b0;
      WD_out       <= '0;
      WR_out       <= '0;
      RegWrite_out <= 1'b0;
      PC_out       <= RESET_PC;
      Instr_out    <= '0;
      Tnew_out     <= '0;
    end else if (flush) begin
      valid_out    <= 1'b0;
      WD_out       <= '0;
      WR_out       <= '0;
      RegWrite_out <= 1'b0;
      PC_out       <= bubble_pc;
      Instr_out    <= '0;
      Tnew_out     <= '0;
    end else if (!stall) begin
      valid_out    <= valid_in;
      WD_out       <= WD_in;
      WR_out       <= WR_in;
      RegWrite_out <= reg_write_qual;
      PC_out       <= PC_in;
      Instr_out    <= Instr_in;
      Tnew_out     <= tnew_next;
    end
  end

  // Purely from registered state so downstream bypass muxes see no input-to-output path.
  assign fwd_ready = valid_out & RegWrite_out & (Tnew_out == '0) & (WR_out != '0);

  a_regwrite_qualified: assert property (@(posedge clk) disable iff (reset)
    RegWrite_out |-> (valid_out && (WR_out != '0)));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; expected bubble PC follows FLUSH_KEEP_PC_EN.
module tb_pipe_stage_reg;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset, stall, flush, valid_in, RegWrite_in;
  logic [31:0] WD_in, PC_in, Instr_in;
  logic [4:0]  WR_in;
  logic [1:0]  Tnew_in;
  logic        valid_out, RegWrite_out, fwd_ready;
  logic [31:0] WD_out, PC_out, Instr_out;
  logic [4:0]  WR_out;
  logic [1:0]  Tnew_out;

  int checks   = 0;
  int failures = 0;

  pipe_stage_reg #(
    .DW(32), .AW(5), .PCW(32), .IW(32), .TW(2), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(valid_in), .WD_in(WD_in), .WR_in(WR_in), .RegWrite_in(RegWrite_in),
    .PC_in(PC_in), .Instr_in(Instr_in), .Tnew_in(Tnew_in),
    .valid_out(valid_out), .WD_out(WD_out), .WR_out(WR_out),
    .RegWrite_out(RegWrite_out), .PC_out(PC_out), .Instr_out(Instr_out),
    .Tnew_out(Tnew_out), .fwd_ready(fwd_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] wd,
                            input logic [4:0] wr, input logic rw, input logic [31:0] pc,
                            input logic [31:0] ins, input logic [1:0] tn, input logic fr);
    check({tag, ".valid"}, 64'(valid_out), 64'(v));
    check({tag, ".WD"}, 64'(WD_out), 64'(wd));
    check({tag, ".WR"}, 64'(WR_out), 64'(wr));
    check({tag, ".RegWrite"}, 64'(RegWrite_out), 64'(rw));
    check({tag, ".PC"}, 64'(PC_out), 64'(pc));
    check({tag, ".Instr"}, 64'(Instr_out), 64'(ins));
    check({tag, ".Tnew"}, 64'(Tnew_out), 64'(tn));
    check({tag, ".fwd"}, 64'(fwd_ready), 64'(fr));
  endtask

  task automatic drive(input logic v, input logic [31:0] wd, input logic [4:0] wr,
                       input logic rw, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [1:0] tn);
    valid_in = v; WD_in = wd; WR_in = wr; RegWrite_in = rw;
    PC_in = pc; Instr_in = ins; Tnew_in = tn;
  endtask

  logic [31:0] flush_pc;

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 5'd3, 1'b1, 32'h4000, 32'hFFFF_FFFF, 2'd3);
    step();
    step();
    expect_out("reset", 1'b0, 32'h0, 5'd0, 1'b0, RST_PC, 32'h0, 2'd0, 1'b0);

    reset = 1'b0;
    drive(1'b1, 32'h1234_5678, 5'd8, 1'b1, 32'h3004, 32'h0109_5020, 2'd2);
    step();
    expect_out("load1", 1'b1, 32'h1234_5678, 5'd8, 1'b1, 32'h3004, 32'h0109_5020, 2'd1, 1'b0);

    drive(1'b1, 32'h1234_5678, 5'd8, 1'b1, 32'h3004, 32'h0109_5020, 2'd1);
    step();
    expect_out("load2", 1'b1, 32'h1234_5678, 5'd8, 1'b1, 32'h3004, 32'h0109_5020, 2'd0, 1'b1);

    drive(1'b1, 32'hAAAA_0001, 5'd0, 1'b1, 32'h3008, 32'h2000_0001, 2'd1);
    step();
    expect_out("r0", 1'b1, 32'hAAAA_0001, 5'd0, 1'b0, 32'h3008, 32'h2000_0001, 2'd0, 1'b0);

    drive(1'b0, 32'h5555_0002, 5'd5, 1'b1, 32'h300C, 32'h2000_0002, 2'd1);
    step();
    expect_out("inval", 1'b0, 32'h5555_0002, 5'd5, 1'b0, 32'h300C, 32'h2000_0002, 2'd0, 1'b0);

    drive(1'b1, 32'h0000_00FF, 5'd5, 1'b1, 32'h3000, 32'h2000_0003, 2'd0);
    step();
    expect_out("tsat", 1'b1, 32'h0000_00FF, 5'd5, 1'b1, 32'h3000, 32'h2000_0003, 2'd0, 1'b1);

    drive(1'b1, 32'h0000_0011, 5'd31, 1'b0, 32'h3008, 32'h2000_0004, 2'd3);
    step();
    expect_out("ldstall", 1'b1, 32'h0000_0011, 5'd31, 1'b0, 32'h3008, 32'h2000_0004, 2'd2, 1'b0);

    stall = 1'b1;
    drive(1'b1, 32'h0000_0022, 5'd7, 1'b1, 32'h300C, 32'h2000_0005, 2'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("stall", 1'b1, 32'h0000_0011, 5'd31, 1'b0, 32'h3008, 32'h2000_0004, 2'd2, 1'b0);
    end
    stall = 1'b0;
    step();
    expect_out("unstall", 1'b1, 32'h0000_0022, 5'd7, 1'b1, 32'h300C, 32'h2000_0005, 2'd0, 1'b1);

`ifdef FLUSH_KEEP_PC_EN
    flush_pc = 32'h3010;
`else
    flush_pc = RST_PC;
`endif
    stall = 1'b1; flush = 1'b1;
    drive(1'b1, 32'h0000_0033, 5'd9, 1'b1, 32'h3010, 32'h2000_0006, 2'd2);
    step();
    expect_out("flushstall", 1'b0, 32'h0, 5'd0, 1'b0, flush_pc, 32'h0, 2'd0, 1'b0);

    stall = 1'b0; flush = 1'b0;
    drive(1'b1, 32'h0000_0044, 5'd10, 1'b1, 32'h3014, 32'h2000_0007, 2'd0);
    step();
    expect_out("postflush", 1'b1, 32'h0000_0044, 5'd10, 1'b1, 32'h3014, 32'h2000_0007, 2'd0, 1'b1);

    reset = 1'b1; stall = 1'b1; flush = 1'b1;
    drive(1'b1, 32'h0000_0055, 5'd11, 1'b1, 32'h3018, 32'h2000_0008, 2'd3);
    step();
    expect_out("rstprio", 1'b0, 32'h0, 5'd0, 1'b0, RST_PC, 32'h0, 2'd0, 1'b0);

    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    step();
    expect_out("postrst", 1'b1, 32'h0000_0055, 5'd11, 1'b1, 32'h3018, 32'h2000_0008, 2'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
